inst_axi_rd_bridge: RTL and testbench

Responder for the instruction-fetch SRAM-like port: accepts fetch requests (req/addr_ok), converts each into a single-beat AXI4 read on a fixed ARID, and returns instruction words in order (data_ok/rdata). Sits between IF stage and the top-level AXI crossbar/arbiter. It is read-only; write requests are refused and flagged.

---
 rtl/inst_axi_rd_bridge_pkg.sv | 12 +
 rtl/inst_axi_rd_bridge.sv | 85 ++++++++
 tb/tb_inst_axi_rd_bridge.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/inst_axi_rd_bridge_pkg.sv
// inst_axi_rd_bridge_pkg: AXI4 read-channel constants shared by the instruction and data bridges
package inst_axi_rd_bridge_pkg;
  localparam logic [1:0] AXI_BURST_INCR   = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY    = 2'b00;
  localparam logic [7:0] AXI_ARLEN_SINGLE = 8'h00;
  localparam logic [3:0] AXI_ARCACHE_DEF  = 4'h0;
  localparam logic [2:0] AXI_ARPROT_DEF   = 3'h0;
  localparam logic [1:0] AXI_ARLOCK_DEF   = 2'h0;
  function automatic logic [2:0] sram_to_axsize(input logic [1:0] size);
    return {1'b0, size};
  endfunction
endpackage

// File: rtl/inst_axi_rd_bridge.sv
// inst_axi_rd_bridge: IF-stage SRAM-like fetch port to single-beat, single-ID AXI4 reads, in order
module inst_axi_rd_bridge
  import inst_axi_rd_bridge_pkg::*;
#(
  parameter int         DEPTH    = 2,
  parameter logic [3:0] ARID_VAL = 4'h0
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [3:0]  inst_sram_wstrb,
  input  logic [31:0] inst_sram_addr,
  input  logic [31:0] inst_sram_wdata,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready,
  output logic        err_wr,
  output logic        err_resp
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  logic          ar_valid_q;
  logic [31:0]   araddr_q;
  logic [2:0]    arsize_q;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          unused_ok;
  assign unused_ok = ^{inst_sram_wstrb, inst_sram_wdata, rid, rlast};
  // No bypass from data_ok: a full bridge only reopens the cycle after a beat returns
  assign inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr & ~ar_valid_q & (cnt < FULL);
  // Beats with nothing outstanding are stale (pre-reset) and silently dropped
  assign inst_sram_data_ok = rvalid & (cnt != '0);
  assign inst_sram_rdata   = rdata;
  assign arid    = ARID_VAL;
  assign araddr  = araddr_q;
  assign arlen   = AXI_ARLEN_SINGLE;
  assign arsize  = arsize_q;
  assign arburst = AXI_BURST_INCR;
  assign arlock  = AXI_ARLOCK_DEF;
  assign arcache = AXI_ARCACHE_DEF;
  assign arprot  = AXI_ARPROT_DEF;
  assign arvalid = ar_valid_q;
  assign rready  = 1'b1;
  always_comb
    cnt_nxt = (inst_sram_addr_ok & ~inst_sram_data_ok) ? cnt + 1'b1 :
              (inst_sram_data_ok & ~inst_sram_addr_ok) ? cnt - 1'b1 : cnt;
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      ar_valid_q <= 1'b0;
      araddr_q   <= '0;
      arsize_q   <= '0;
      cnt        <= '0;
      err_wr     <= 1'b0;
      err_resp   <= 1'b0;
    end else begin
      if (inst_sram_addr_ok) begin
        ar_valid_q <= 1'b1;
        araddr_q   <= inst_sram_addr;
        arsize_q   <= sram_to_axsize(inst_sram_size);
      end else if (ar_valid_q & arready) begin
        ar_valid_q <= 1'b0;
      end
      cnt      <= cnt_nxt;
      err_wr   <= err_wr | (inst_sram_req & inst_sram_wr);
      err_resp <= err_resp | (inst_sram_data_ok & (rresp != AXI_RESP_OKAY));
    end
endmodule

// File: tb/tb_inst_axi_rd_bridge.sv
// tb_inst_axi_rd_bridge: per-cycle vector table with an AXI slave model and an in-order read scoreboard
module tb_inst_axi_rd_bridge;
  typedef struct {
    logic        req;
    logic        wr;
    logic [31:0] addr;
    logic        ard;
    logic        rgo;
    logic [1:0]  rresp;
    logic        aok;
    logic        dok;
    logic        arv;
  } vec_t;
  localparam logic [31:0] A0 = 32'h1C00_0000;
  localparam logic [31:0] A1 = 32'h1C00_0004;
  localparam logic [31:0] A2 = 32'h1C00_0008;
  localparam logic [31:0] A3 = 32'h1C00_000C;
  logic clk = 1'b0;
  logic resetn = 1'b1;
  logic inst_sram_req = 1'b0, inst_sram_wr = 1'b0;
  logic [1:0] inst_sram_size = 2'd2;
  logic [3:0] inst_sram_wstrb = 4'h0;
  logic [31:0] inst_sram_addr = '0, inst_sram_wdata = '0;
  logic inst_sram_addr_ok, inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize, arprot;
  logic [1:0] arburst, arlock;
  logic [3:0] arcache;
  logic arvalid, arready = 1'b0;
  logic [3:0] rid = 4'h0;
  logic [31:0] rdata = '0;
  logic [1:0] rresp = 2'b00;
  logic rlast = 1'b1, rvalid = 1'b0, rready;
  logic err_wr, err_resp;
  int errors = 0, checks = 0;
  logic [31:0] sb[$];
  logic [31:0] arq[$];
  logic [31:0] exp_araddr = '0;
  vec_t tbl[$];
  always #5 clk = ~clk;
  inst_axi_rd_bridge #(.DEPTH(2), .ARID_VAL(4'h0)) dut (
    .clk(clk), .resetn(resetn),
    .inst_sram_req(inst_sram_req), .inst_sram_wr(inst_sram_wr), .inst_sram_size(inst_sram_size),
    .inst_sram_wstrb(inst_sram_wstrb), .inst_sram_addr(inst_sram_addr), .inst_sram_wdata(inst_sram_wdata),
    .inst_sram_addr_ok(inst_sram_addr_ok), .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst), .arlock(arlock),
    .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .err_wr(err_wr), .err_resp(err_resp)
  );
  function automatic logic [31:0] mem(input logic [31:0] a);
    return a ^ 32'h1E80_0C06;
  endfunction
  function automatic vec_t mk(input logic req, input logic wr, input logic [31:0] addr, input logic ard,
                              input logic rgo, input logic [1:0] rr, input logic aok, input logic dok,
                              input logic arv);
    vec_t v;
    v.req = req; v.wr = wr; v.addr = addr; v.ard = ard; v.rgo = rgo; v.rresp = rr;
    v.aok = aok; v.dok = dok; v.arv = arv;
    return v;
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask
  task automatic idle();
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; arready = 1'b0; rvalid = 1'b0; rresp = 2'b00;
  endtask
  task automatic step(input vec_t v);
    @(posedge clk); #1;
    inst_sram_req = v.req; inst_sram_wr = v.wr; inst_sram_addr = v.addr; inst_sram_size = 2'd2;
    arready = v.ard; rvalid = v.rgo; rresp = v.rresp;
    rdata = (arq.size() > 0) ? mem(arq[0]) : 32'hDEAD_BEEF;
    @(negedge clk);
    chk("addr_ok", {31'd0, inst_sram_addr_ok}, {31'd0, v.aok});
    chk("data_ok", {31'd0, inst_sram_data_ok}, {31'd0, v.dok});
    chk("arvalid", {31'd0, arvalid}, {31'd0, v.arv});
    chk("rready", {31'd0, rready}, 32'd1);
    if (arvalid) begin
      chk("araddr", araddr, exp_araddr);
      chk("arsize", {29'd0, arsize}, 32'd2);
    end
    if (inst_sram_data_ok) begin
      if (sb.size() == 0) chk("sb_empty", inst_sram_rdata, 32'hFFFF_FFFF);
      else chk("rdata", inst_sram_rdata, sb.pop_front());
    end
    if (rvalid && arq.size() > 0) void'(arq.pop_front());
    if (inst_sram_addr_ok) begin
      sb.push_back(mem(inst_sram_addr));
      exp_araddr = inst_sram_addr;
    end
    if (arvalid && arready) arq.push_back(araddr);
  endtask
  initial begin
    #1 resetn = 1'b0;
    #2;
    chk("rst_addr_ok", {31'd0, inst_sram_addr_ok}, 32'd0);
    chk("rst_data_ok", {31'd0, inst_sram_data_ok}, 32'd0);
    chk("rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("rst_araddr", araddr, 32'd0);
    chk("rst_arsize", {29'd0, arsize}, 32'd0);
    chk("rst_err", {30'd0, err_wr, err_resp}, 32'd0);
    chk("ar_consts", {arid, arlen, arburst, arlock, arcache, arprot, 5'd0}, {4'h0, 8'h00, 2'b01, 2'b00, 4'h0, 3'h0, 5'd0});
    @(negedge clk); @(negedge clk);
    resetn = 1'b1;
    // single fetch, 2-cycle latency
    tbl.push_back(mk(1, 0, A0, 1, 0, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 0, A0, 1, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mk(0, 0, A0, 1, 1, 2'b00, 0, 1, 0));
    // back-to-back accepts, accept and return in the same cycle
    tbl.push_back(mk(1, 0, A1, 1, 0, 2'b00, 1, 0, 0));
    tbl.push_back(mk(1, 0, A2, 1, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mk(1, 0, A2, 1, 1, 2'b00, 1, 1, 0));
    tbl.push_back(mk(0, 0, A2, 1, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mk(0, 0, A2, 0, 1, 2'b00, 0, 1, 0));
    // AR backpressure for 5 cycles
    tbl.push_back(mk(1, 0, A0, 0, 0, 2'b00, 1, 0, 0));
    for (int i = 0; i < 5; i++) tbl.push_back(mk(1, 0, A1, 0, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mk(1, 0, A1, 1, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mk(1, 0, A1, 0, 0, 2'b00, 1, 0, 0));
    // full at DEPTH=2, no bypass on the freeing beat
    tbl.push_back(mk(1, 0, A2, 1, 0, 2'b00, 0, 0, 1));
    tbl.push_back(mk(1, 0, A2, 0, 0, 2'b00, 0, 0, 0));
    tbl.push_back(mk(1, 0, A2, 0, 1, 2'b00, 0, 1, 0));
    tbl.push_back(mk(1, 0, A2, 0, 0, 2'b00, 1, 0, 0));
    tbl.push_back(mk(0, 0, A2, 1, 1, 2'b00, 0, 1, 1));
    tbl.push_back(mk(0, 0, A2, 0, 1, 2'b00, 0, 1, 0));
    // stale beat with nothing outstanding
    tbl.push_back(mk(0, 0, A2, 0, 1, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 0, A2, 0, 0, 2'b00, 0, 0, 0));
    foreach (tbl[i]) step(tbl[i]);
    chk("sb_drained", sb.size(), 32'd0);
    chk("err_clean", {30'd0, err_wr, err_resp}, 32'd0);
    // write request refused, error sticky
    step(mk(1, 1, A0, 1, 0, 2'b00, 0, 0, 0));
    step(mk(0, 0, A0, 0, 0, 2'b00, 0, 0, 0));
    chk("err_wr", {31'd0, err_wr}, 32'd1);
    // SLVERR beat still returns data
    step(mk(1, 0, A3, 1, 0, 2'b00, 1, 0, 0));
    step(mk(0, 0, A3, 1, 0, 2'b00, 0, 0, 1));
    chk("err_resp_pre", {31'd0, err_resp}, 32'd0);
    step(mk(0, 0, A3, 0, 1, 2'b10, 0, 1, 0));
    step(mk(0, 0, A3, 0, 0, 2'b00, 0, 0, 0));
    chk("err_resp", {31'd0, err_resp}, 32'd1);
    chk("err_wr_sticky", {31'd0, err_wr}, 32'd1);
    // asynchronous reset with a request outstanding and arvalid up
    step(mk(1, 0, A1, 0, 0, 2'b00, 1, 0, 0));
    step(mk(0, 0, A1, 0, 0, 2'b00, 0, 0, 1));
    @(posedge clk); #2;
    idle();
    resetn = 1'b0;
    #1;
    chk("mid_rst_arvalid", {31'd0, arvalid}, 32'd0);
    chk("mid_rst_araddr", araddr, 32'd0);
    chk("mid_rst_arsize", {29'd0, arsize}, 32'd0);
    chk("mid_rst_oks", {30'd0, inst_sram_addr_ok, inst_sram_data_ok}, 32'd0);
    chk("mid_rst_err", {30'd0, err_wr, err_resp}, 32'd0);
    @(negedge clk);
    resetn = 1'b1;
    sb.delete();
    arq.delete();
    step(mk(0, 0, A0, 0, 1, 2'b00, 0, 0, 0));
    step(mk(1, 0, A0, 1, 0, 2'b00, 1, 0, 0));
    step(mk(0, 0, A0, 1, 0, 2'b00, 0, 0, 1));
    step(mk(0, 0, A0, 0, 1, 2'b00, 0, 1, 0));
    step(mk(0, 0, A0, 0, 1, 2'b00, 0, 0, 0));
    chk("sb_final", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
